// File: rtl/floating_point_accumulator.sv
// Streaming floating-point accumulator: folds a valid/ready operand stream into a
// running sum through one combinational IEEE-754 adder and emits the sum on `last`.

module floating_point_adder #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
  input  logic                                   subtract,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] result,
  output logic                                   underflow,
  output logic                                   overflow,
  output logic                                   invalid_operation
);
  localparam int E  = EXPONENT_WIDTH;
  localparam int M  = MANTISSA_WIDTH;
  localparam int W  = E + M + 1;
  localparam int XW = M + 4;  // hidden bit, fraction, guard, round, sticky
  localparam logic [E-1:0] EXP_MAX = '1;

  logic          sa, sb, sx, sy, swap;
  logic [E-1:0]  ea, eb;
  logic [M-1:0]  fa, fb;
  logic          a_nan, b_nan, a_inf, b_inf, a_snan, b_snan, inf_clash;
  logic [E+1:0]  eff_a, eff_b, ex, ey, d, d_sat, e_norm, e_fin;
  logic [XW-1:0] man_a, man_b, mx, my, my_al, mant_n;
  logic [2*XW-1:0] my_wide;
  logic [XW:0]   sum;
  logic [M+1:0]  rounded;
  logic          round_up, inexact, tiny;
  int            lz, shift;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    sa = a[W-1];           ea = a[W-2:M]; fa = a[M-1:0];
    sb = b[W-1] ^ subtract; eb = b[W-2:M]; fb = b[M-1:0];
    a_nan  = (ea == EXP_MAX) && (fa != '0);
    b_nan  = (eb == EXP_MAX) && (fb != '0);
    a_inf  = (ea == EXP_MAX) && (fa == '0);
    b_inf  = (eb == EXP_MAX) && (fb == '0);
    a_snan = a_nan && !fa[M-1];
    b_snan = b_nan && !fb[M-1];
    inf_clash = a_inf && b_inf && (sa != sb);

    // Subnormals share the minimum exponent and lack the hidden bit.
    eff_a = (ea == '0) ? (E+2)'(1) : {2'b00, ea};
    eff_b = (eb == '0) ? (E+2)'(1) : {2'b00, eb};
    man_a = {ea != '0, fa, 3'b000};
    man_b = {eb != '0, fb, 3'b000};

    swap = b[W-2:0] > a[W-2:0];
    sx = swap ? sb : sa;       sy = swap ? sa : sb;
    ex = swap ? eff_b : eff_a; ey = swap ? eff_a : eff_b;
    mx = swap ? man_b : man_a; my = swap ? man_a : man_b;

    d       = ex - ey;
    d_sat   = (d > (E+2)'(XW)) ? (E+2)'(XW) : d;
    my_wide = {my, {XW{1'b0}}} >> d_sat;
    my_al   = my_wide[2*XW-1:XW] | {{(XW-1){1'b0}}, |my_wide[XW-1:0]};
    sum     = (sx == sy) ? ({1'b0, mx} + {1'b0, my_al}) : ({1'b0, mx} - {1'b0, my_al});

    lz = XW;
    for (int i = 0; i < XW; i++) if (sum[i]) lz = XW - 1 - i;
    shift = (lz < int'(ex) - 1) ? lz : int'(ex) - 1;
    if (sum[XW]) begin
      mant_n = {sum[XW:2], sum[1] | sum[0]};
      e_norm = ex + (E+2)'(1);
    end else begin
      mant_n = sum[XW-1:0] << shift;
      e_norm = ex - (E+2)'(shift);
    end

    // Round to nearest, ties to even; a mantissa carry bumps the exponent.
    round_up = mant_n[2] & (mant_n[1] | mant_n[0] | mant_n[3]);
    inexact  = |mant_n[2:0];
    tiny     = !mant_n[XW-1];
    rounded  = {1'b0, mant_n[XW-1:3]} + {{(M+1){1'b0}}, round_up};
    if (rounded[M+1])  e_fin = e_norm + (E+2)'(1);
    else if (rounded[M]) e_fin = e_norm;
    else               e_fin = '0;

    result            = {sx, e_fin[E-1:0], rounded[M-1:0]};
    underflow         = 1'b0;
    overflow          = 1'b0;
    invalid_operation = 1'b0;
    if (a_nan || b_nan || inf_clash) begin
      result            = {1'b0, EXP_MAX, 1'b1, {(M-1){1'b0}}};
      invalid_operation = a_snan || b_snan || inf_clash;
    end else if (a_inf) begin
      result = a;
    end else if (b_inf) begin
      result = {sb, EXP_MAX, {M{1'b0}}};
    end else if (sum == '0) begin
      result = {sa & sb, {(W-1){1'b0}}};
    end else if (e_fin >= {2'b00, EXP_MAX}) begin
      result   = {sx, EXP_MAX, {M{1'b0}}};
      overflow = 1'b1;
    end else begin
      underflow = tiny && inexact;
    end
  end
endmodule

module floating_point_accumulator #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int COUNT_WIDTH    = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] in_data,
  input  logic                                   in_subtract,
  input  logic                                   in_last,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out_data,
  output logic [COUNT_WIDTH-1:0]                 out_count,
  output logic                                   underflow_flag,
  output logic                                   overflow_flag,
  output logic                                   invalid_operation_flag
);
  localparam int FLOAT_BIT_WIDTH = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;

  typedef enum logic {ACCUM, DONE} state_t;

  state_t                     state, state_next;
  logic [FLOAT_BIT_WIDTH-1:0] acc, sum;
  logic [COUNT_WIDTH-1:0]     count;
  logic                       first, accept;
  logic                       uf, of, nv, add_uf, add_of, add_nv;

  floating_point_adder #(
    .EXPONENT_WIDTH(EXPONENT_WIDTH),
    .MANTISSA_WIDTH(MANTISSA_WIDTH)
  ) u_adder (
    .a                (acc),
    .b                (in_data),
    .subtract         (in_subtract),
    .result           (sum),
    .underflow        (add_uf),
    .overflow         (add_of),
    .invalid_operation(add_nv)
  );

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_next = state;
    if (state == ACCUM && accept && in_last) state_next = DONE;
    else if (state == DONE && out_ready)     state_next = ACCUM;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0; count <= '0; first <= 1'b1;
      uf  <= 1'b0; of <= 1'b0; nv <= 1'b0;
    end else if (state == DONE && out_ready) begin
      acc <= '0; count <= '0; first <= 1'b1;
      uf  <= 1'b0; of <= 1'b0; nv <= 1'b0;
    end else if (accept) begin
      if (first) begin
        // Load bypasses the adder so -0 and NaN payloads survive untouched.
        acc   <= {in_data[FLOAT_BIT_WIDTH-1] ^ in_subtract, in_data[FLOAT_BIT_WIDTH-2:0]};
        first <= 1'b0;
      end else begin
        acc <= sum;
        uf  <= uf | add_uf;
        of  <= of | add_of;
        nv  <= nv | add_nv;
      end
      if (count != '1) count <= count + 1'b1;
    end
  end

  assign out_data               = acc;
  assign out_count              = count;
  assign underflow_flag         = uf;
  assign overflow_flag          = of;
  assign invalid_operation_flag = nv;
endmodule

// File: doc/floating_point_accumulator.md
# floating_point_accumulator

Sequential accumulation stage built around `floating_point_adder`. It consumes a valid/ready stream of floating-point operands and folds each one into a running sum register through a single combinational adder instance. On the beat marked last, it presents the registered sum, beat count and sticky exception flags on an output handshake. It sits directly downstream of operand producers, such as dot-product or reduction front ends, and owns the only adder in its path.

## Interface

Parameters:
- `EXPONENT_WIDTH`, default 8: exponent field width, passed to the adder.
- `MANTISSA_WIDTH`, default 23: mantissa field width, passed to the adder.
- `COUNT_WIDTH`, default 8: width of the beat counter.
- Local `FLOAT_BIT_WIDTH` = `EXPONENT_WIDTH + MANTISSA_WIDTH + 1`.

Ports:
- `clk`, input, 1: clock. The block has one clock.
- `rst`, input, 1: reset, asynchronous and active-high.
- `in_valid`, input, 1: operand beat valid.
- `in_ready`, output, 1: block accepts a beat.
- `in_data`, input, `FLOAT_BIT_WIDTH`: operand.
- `in_subtract`, input, 1: subtract this operand instead of adding it.
- `in_last`, input, 1: final beat of the sequence.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `out_data`, output, `FLOAT_BIT_WIDTH`: accumulated sum.
- `out_count`, output, `COUNT_WIDTH`: beats accepted in the sequence. Saturating.
- `underflow_flag`, output, 1: sticky OR of adder underflow over the sequence.
- `overflow_flag`, output, 1: sticky OR of adder overflow over the sequence.
- `invalid_operation_flag`, output, 1: sticky OR of adder invalid over the sequence.

## Operation

States are ACCUM and DONE. Reset enters ACCUM.

Registers:
- `acc`
- `count`
- `first` (set at reset)
- three sticky flags

Outputs read the registers directly.

Beat handshake:
- A beat is accepted when `in_valid && in_ready`.
- `in_ready` = 1 only in ACCUM. It is decoded from state only, so there is no combinational path from `out_ready`.

Accepted beat with `first` = 1 (load beat):
- `acc` <= `in_data`, with the sign bit inverted if `in_subtract`. This is exact: the adder is bypassed, so -0 and NaN payloads are preserved.
- Flags are unchanged (still 0).
- `first` <= 0.

Accepted beat with `first` = 0:
- `acc` <= adder(a=`acc`, b=`in_data`, subtract=`in_subtract`).
- Each sticky flag <= flag | the adder's flag.

Counter on every accepted beat:
- `count` <= `count` + 1, saturating at 2^`COUNT_WIDTH`−1. It never wraps.

Accepted beat with `in_last` = 1:
- State → DONE. The updated `acc`, `count` and flags are registered in the same edge.

In DONE:
- `out_valid` = 1. `out_data`, `out_count` and the flags hold stable.
- On `out_ready` = 1 the state returns to ACCUM and, on the same edge, clears `acc` to 0, `count` to 0 and all flags to 0, and sets `first` to 1.

Outside DONE:
- `out_valid` = 0.
- `out_data`, `out_count` and the flags expose the in-progress registers. They are not meaningful until `out_valid` is high.

Arithmetic, rounding, NaN and infinity handling are entirely the adder's. An accumulated ±inf or NaN propagates per the adder.

## Timing

- Reset values: `acc` = 0, `count` = 0, flags = 0, `first` = 1, state ACCUM.
- Reset effect on outputs: `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `out_count` = 0, all flags 0.
- Reset is asynchronous. Asserting it mid-sequence or in DONE discards everything immediately.
- Throughput: one beat per cycle in ACCUM.
- Latency: `out_valid` rises on the clock edge that accepts the last beat, so the result appears one cycle after the last-beat handshake.
- Result transfer: takes place when `out_valid && out_ready`. `in_ready` returns on the following cycle, giving a minimum one-cycle bubble between sequences.
- Backpressure in DONE: `in_valid` is ignored, and `in_data`/`in_last` may change freely without effect.
- Single-beat sequence (first and last on the same beat): produces the load value, `count` = 1, flags 0.
- Counter saturation: at 2^`COUNT_WIDTH`−1 the sum keeps accumulating and only the count stops.
- Adder placement: it is the single combinational path from `acc`/`in_data` to `acc`. There is no pipelining inside the block.

## Test plan

- Add sequence: 0x40400000 (3.0), then 0x40800000 (4.0) with last, `subtract` = 0 → one cycle later `out_valid` = 1, `out_data` = 0x40E00000 (7.0), `out_count` = 2, flags 000.
- Subtract sequence: 0x40400000 (3.0), then 0x40800000 with `subtract` = 1 and last → `out_data` = 0xBF800000 (−1.0), `out_count` = 2.
- Single negated load: 0x40400000 with `subtract` = 1 and last → `out_data` = 0xC0400000 (−3.0), `out_count` = 1, flags 000, with no adder involvement.
- Overflow: 0x7F7FFFFF, 0x7F7FFFFF, then 0x3F800000 (1.0) with last → `out_data` = 0x7F800000, `overflow_flag` = 1 held through the final beat.
- Backpressure: hold `out_ready` = 0 for 3 cycles after 7.0 completes while driving `in_valid` = 1 → `in_ready` = 0, `out_data` holds 0x40E00000. On release, the next sequence 0x3F800000 with last yields 0x3F800000 and `out_count` = 1 (state was cleared).
- Reset mid-sequence: accept 0x40400000, assert `rst` asynchronously between edges → outputs go to reset values immediately. A following sequence 0x40800000 with last yields 0x40800000 and `out_count` = 1.
